// File: rtl/lc4_isa_pkg.sv
// Shared LC4 ISA definitions: opcode encodings, instruction field positions,
// condition-code bit positions and the sequencer state encoding.
package lc4_isa_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_BRZ   = 5'b00001;
  localparam logic [4:0] OP_BRZP  = 5'b00010;
  localparam logic [4:0] OP_BRNP  = 5'b00011;
  localparam logic [4:0] OP_BRNZ  = 5'b00100;
  localparam logic [4:0] OP_ADD   = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_ADDI  = 5'b00111;
  localparam logic [4:0] OP_JSR   = 5'b01000;
  localparam logic [4:0] OP_AND   = 5'b01001;
  localparam logic [4:0] OP_RTI   = 5'b01010;
  localparam logic [4:0] OP_CONST = 5'b01011;
  localparam logic [4:0] OP_SLL   = 5'b01100;
  localparam logic [4:0] OP_SRL   = 5'b01101;
  localparam logic [4:0] OP_SDRH  = 5'b01110;
  localparam logic [4:0] OP_SDRL  = 5'b01111;
  localparam logic [4:0] OP_CHKL  = 5'b10000;
  localparam logic [4:0] OP_SDL   = 5'b10010;
  localparam logic [4:0] OP_CHKH  = 5'b10011;
  localparam logic [4:0] OP_TCS   = 5'b10100;
  localparam logic [4:0] OP_TCDH  = 5'b10101;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  localparam int unsigned OPC_HI = 19;
  localparam int unsigned OPC_LO = 15;
  localparam int unsigned RD_HI  = 14;
  localparam int unsigned RD_LO  = 10;
  localparam int unsigned RS_HI  = 9;
  localparam int unsigned RS_LO  = 5;
  localparam int unsigned RT_HI  = 4;
  localparam int unsigned RT_LO  = 0;

  localparam int unsigned NZP_N = 2;
  localparam int unsigned NZP_Z = 1;
  localparam int unsigned NZP_P = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE
  } state_e;

endpackage

// File: rtl/lc4_branch_eval.sv
// Branch resolution: decides from the opcode and the held NZP flags whether
// a control-transfer instruction redirects the PC.
module lc4_branch_eval
  import lc4_isa_pkg::*;
(
  input  logic [4:0] i_opcode,
  input  logic [2:0] i_nzp,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_opcode)
      OP_BRZ:  o_taken = i_nzp[NZP_Z];
      OP_BRZP: o_taken = i_nzp[NZP_Z] | i_nzp[NZP_P];
      OP_BRNP: o_taken = i_nzp[NZP_N] | i_nzp[NZP_P];
      OP_BRNZ: o_taken = i_nzp[NZP_N] | i_nzp[NZP_Z];
      OP_JSR:  o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/lc4_issue_seq.sv
// Multi-cycle LC4 issue sequencer: FETCH -> DECODE -> EXEC per instruction,
// driving the ALU and retiring its result into the register file and flags.
module lc4_issue_seq
  import lc4_isa_pkg::*;
#(
  parameter int WORD_SIZE = 256,
  parameter int INSN      = 19,
  parameter int IADDR     = 10,
  parameter int DADDR     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [IADDR:0]       i_start_pc,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_illegal,
  output logic [IADDR:0]       o_imem_addr,
  input  logic [INSN:0]        i_imem_data,
  output logic [DADDR:0]       o_rs_addr,
  output logic [DADDR:0]       o_rt_addr,
  input  logic [WORD_SIZE-1:0] i_rs_data,
  input  logic [WORD_SIZE-1:0] i_rt_data,
  output logic                 o_rd_we,
  output logic [DADDR:0]       o_rd_addr,
  output logic [WORD_SIZE-1:0] o_rd_data,
  output logic [INSN:0]        o_alu_insn,
  output logic [IADDR:0]       o_alu_pc,
  output logic [WORD_SIZE-1:0] o_alu_r1,
  output logic [WORD_SIZE-1:0] o_alu_r2,
  output logic                 o_alu_carry,
  input  logic [WORD_SIZE-1:0] i_alu_result
);

  state_e         state_q, state_d;
  logic [IADDR:0] pc_q, pc_d;
  logic [2:0]     nzp_q, nzp_d;
  logic           carry_q, carry_d;
  logic [INSN:0]  insn_q, insn_d;
  logic           illegal_q, illegal_d;

  logic [4:0] opcode;
  logic       wb_op;
  logic       known_op;
  logic       taken;
  logic       exec;

  assign opcode = insn_q[OPC_HI:OPC_LO];
  assign exec   = (state_q == S_EXEC);

  lc4_branch_eval u_branch (
    .i_opcode (opcode),
    .i_nzp    (nzp_q),
    .o_taken  (taken)
  );

  always_comb begin
    wb_op    = 1'b0;
    known_op = 1'b1;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADDI, OP_AND, OP_RTI, OP_CONST, OP_SLL, OP_SRL,
      OP_SDRH, OP_SDRL, OP_SDL, OP_TCS, OP_TCDH:
        wb_op = 1'b1;
      OP_NOP, OP_BRZ, OP_BRZP, OP_BRNP, OP_BRNZ, OP_JSR, OP_CHKL, OP_CHKH,
      OP_HALT:
        wb_op = 1'b0;
      default:
        known_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    nzp_d     = nzp_q;
    carry_d   = carry_q;
    insn_d    = insn_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          pc_d      = i_start_pc;
          illegal_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        insn_d  = i_imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 1'b1;
        if (taken) pc_d = i_alu_result[IADDR:0];
        if (wb_op) begin
          if (i_alu_result == '0)          nzp_d = 3'b010;
          else if (i_alu_result[WORD_SIZE-1]) nzp_d = 3'b100;
          else                             nzp_d = 3'b001;
        end
        if (opcode == OP_CHKL) carry_d = i_alu_result[0];
        if (opcode == OP_CHKH) carry_d = i_alu_result[WORD_SIZE-1];
        if (opcode == OP_HALT) begin
          pc_d    = pc_q;
          state_d = S_DONE;
        end
        if (!known_op) illegal_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      nzp_q     <= 3'b010;
      carry_q   <= 1'b0;
      insn_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      nzp_q     <= nzp_d;
      carry_q   <= carry_d;
      insn_q    <= insn_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || exec;
  assign o_done      = (state_q == S_DONE);
  assign o_illegal   = illegal_q;
  assign o_imem_addr = (state_q == S_FETCH) ? pc_q : '0;

  // Regfile read is synchronous, so addresses come straight from the returning
  // instruction word to have operands ready in EXEC.
  assign o_rs_addr = (state_q == S_DECODE) ? i_imem_data[RS_HI:RS_LO] : '0;
  assign o_rt_addr = (state_q == S_DECODE) ? i_imem_data[RT_HI:RT_LO] : '0;

  assign o_rd_we   = exec && wb_op && !rst;
  assign o_rd_addr = exec ? insn_q[RD_HI:RD_LO] : '0;
  assign o_rd_data = exec ? i_alu_result : '0;

  assign o_alu_insn  = exec ? insn_q : '0;
  assign o_alu_pc    = exec ? pc_q : '0;
  assign o_alu_r1    = exec ? i_rs_data : '0;
  assign o_alu_r2    = exec ? i_rt_data : '0;
  assign o_alu_carry = exec && carry_q;

endmodule

// File: tb/tb_lc4_issue_seq.sv
// Scoreboard bench for lc4_issue_seq with behavioural imem, regfile and ALU.
module tb_lc4_issue_seq;

  localparam int W = 256;

  localparam int unsigned K_FETCH = 0;
  localparam int unsigned K_WB    = 1;
  localparam int unsigned K_DONE  = 2;

  typedef struct {
    int unsigned kind;
    logic [10:0] addr;
    logic [W-1:0] data;
    logic        carry;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [10:0]   i_start_pc;
  logic          o_busy, o_done, o_illegal;
  logic [10:0]   o_imem_addr;
  logic [19:0]   i_imem_data;
  logic [4:0]    o_rs_addr, o_rt_addr;
  logic [W-1:0]  i_rs_data, i_rt_data;
  logic          o_rd_we;
  logic [4:0]    o_rd_addr;
  logic [W-1:0]  o_rd_data;
  logic [19:0]   o_alu_insn;
  logic [10:0]   o_alu_pc;
  logic [W-1:0]  o_alu_r1, o_alu_r2;
  logic          o_alu_carry;
  logic [W-1:0]  i_alu_result;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned run_cyc = 0;
  ev_t sb[$];

  logic [19:0]  imem [0:2047];
  logic [W-1:0] rf   [0:31];
  logic         tb_we = 1'b0;
  logic [4:0]   tb_wa = '0;
  logic [W-1:0] tb_wd = '0;

  always #5 clk = ~clk;

  lc4_issue_seq #(.WORD_SIZE(256), .INSN(19), .IADDR(10), .DADDR(4)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_start_pc(i_start_pc),
    .o_busy(o_busy), .o_done(o_done), .o_illegal(o_illegal),
    .o_imem_addr(o_imem_addr), .i_imem_data(i_imem_data),
    .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .o_rd_we(o_rd_we), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
    .o_alu_insn(o_alu_insn), .o_alu_pc(o_alu_pc),
    .o_alu_r1(o_alu_r1), .o_alu_r2(o_alu_r2), .o_alu_carry(o_alu_carry),
    .i_alu_result(i_alu_result)
  );

  // Synchronous-read memories and the regfile write port
  always @(posedge clk) begin
    i_imem_data <= imem[o_imem_addr];
    i_rs_data   <= rf[o_rs_addr];
    i_rt_data   <= rf[o_rt_addr];
    if (o_rd_we) rf[o_rd_addr] <= o_rd_data;
    if (tb_we)   rf[tb_wa] <= tb_wd;
  end

  // Reference ALU: imm10 = insn[9:0] sign-extended; branches target pc+1+imm
  logic [4:0]   alu_op;
  logic [W-1:0] alu_imm;
  logic [10:0]  alu_tgt;
  always_comb begin
    alu_op  = o_alu_insn[19:15];
    alu_imm = {{(W-10){o_alu_insn[9]}}, o_alu_insn[9:0]};
    alu_tgt = o_alu_pc + 11'd1 + alu_imm[10:0];
    case (alu_op)
      5'b00101: i_alu_result = o_alu_r1 + o_alu_r2;
      5'b00110: i_alu_result = o_alu_r1 - o_alu_r2;
      5'b01011: i_alu_result = alu_imm;
      5'b10000: i_alu_result = o_alu_r1;
      5'b10101: i_alu_result = '0 - o_alu_r1;
      5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000:
        i_alu_result = {{(W-11){1'b0}}, alu_tgt};
      default:  i_alu_result = '0;
    endcase
  end

  function automatic logic [19:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [9:0] lo);
    return {op, rd, lo};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_f(input logic [10:0] a);
    ev_t e;
    e.kind = K_FETCH; e.addr = a; e.data = '0; e.carry = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [W-1:0] d, input logic c);
    ev_t e;
    e.kind = K_WB; e.addr = {6'b0, rd}; e.data = d; e.carry = c;
    sb.push_back(e);
  endtask

  task automatic push_done();
    ev_t e;
    e.kind = K_DONE; e.addr = '0; e.data = '0; e.carry = 1'b0;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input int unsigned kind, input logic [10:0] addr,
                           input logic [W-1:0] data, input logic carry);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d addr=%h, required no event", kind, addr);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || (kind != K_DONE && e.addr != addr) ||
          (kind == K_WB && (e.data != data || e.carry != carry))) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d addr=%h data=%h c=%b, required kind=%0d addr=%h data=%h c=%b",
                 kind, addr, data, carry, e.kind, e.addr, e.data, e.carry);
      end
    end
  endtask

  // Monitor: every third busy cycle from start is a FETCH
  always @(negedge clk) begin
    if (rst) begin
      run_cyc = 0;
      chk("rst_no_we", {255'b0, o_rd_we}, '0);
    end else begin
      if (o_busy) begin
        if (run_cyc % 3 == 0) expect_ev(K_FETCH, o_imem_addr, '0, 1'b0);
        run_cyc++;
      end
      if (o_rd_we) expect_ev(K_WB, {6'b0, o_rd_addr}, o_rd_data, o_alu_carry);
      if (o_done) begin
        expect_ev(K_DONE, '0, '0, 1'b0);
        run_cyc = 0;
      end
    end
  end

  task automatic start_run(input logic [10:0] pc);
    @(posedge clk); #1;
    i_start = 1'b1; i_start_pc = pc;
    @(posedge clk); #1;
    i_start = 1'b0; i_start_pc = '0;
  endtask

  task automatic wait_done(input string name);
    int unsigned n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (o_done) break;
    end
    checks++;
    if (n == 100) begin
      errors++;
      $display("FAIL %s_timeout: o_done not seen within 100 cycles", name);
    end
    #2;
    chk({name, "_drain"}, W'(sb.size()), '0);
    sb.delete();
  endtask

  task automatic set_reg(input logic [4:0] a, input logic [W-1:0] d);
    @(posedge clk); #1;
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic reset_outputs(input string name);
    chk({name, "_busy"},  {255'b0, o_busy}, '0);
    chk({name, "_done"},  {255'b0, o_done}, '0);
    chk({name, "_ill"},   {255'b0, o_illegal}, '0);
    chk({name, "_we"},    {255'b0, o_rd_we}, '0);
    chk({name, "_iaddr"}, {245'b0, o_imem_addr}, '0);
    chk({name, "_apc"},   {245'b0, o_alu_pc}, '0);
    chk({name, "_ainsn"}, {236'b0, o_alu_insn}, '0);
    chk({name, "_rdata"}, o_rd_data, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < 2048; i++) imem[i] = '0;
    for (int unsigned i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = W'(5); rf[2] = W'(5); rf[7] = W'(32'h77);

    imem[11'h010] = mk(5'b11111, 5'd0, 10'd0);
    imem[11'h040] = mk(5'b01011, 5'd3, 10'h3FF);
    imem[11'h041] = mk(5'b00010, 5'd0, 10'd2);
    imem[11'h042] = mk(5'b00011, 5'd0, 10'd2);
    imem[11'h045] = mk(5'b11111, 5'd0, 10'd0);
    imem[11'h020] = mk(5'b00110, 5'd4, {5'd1, 5'd2});
    imem[11'h021] = mk(5'b00001, 5'd0, 10'd4);
    imem[11'h022] = mk(5'b11111, 5'd0, 10'd0);
    imem[11'h026] = mk(5'b11111, 5'd0, 10'd0);
    imem[11'h030] = mk(5'b10000, 5'd0, {5'd1, 5'd0});
    imem[11'h031] = mk(5'b10101, 5'd5, {5'd1, 5'd0});
    imem[11'h032] = mk(5'b11111, 5'd0, 10'd0);
    imem[11'h7FF] = mk(5'b00000, 5'd0, 10'd0);
    imem[11'h000] = mk(5'b11111, 5'd0, 10'd0);
    imem[11'h050] = mk(5'b00101, 5'd6, {5'd1, 5'd2});
    imem[11'h051] = mk(5'b11000, 5'd9, {5'd1, 5'd2});
    imem[11'h052] = mk(5'b11111, 5'd0, 10'd0);
    imem[11'h060] = mk(5'b00101, 5'd7, {5'd1, 5'd2});
    imem[11'h070] = mk(5'b00001, 5'd0, 10'd1);
    imem[11'h072] = mk(5'b10101, 5'd8, {5'd1, 5'd0});
    imem[11'h073] = mk(5'b11111, 5'd0, 10'd0);

    rst = 1'b1; i_start = 1'b0; i_start_pc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_outputs("reset");

    // HALT alone: 3 busy cycles, done on the 4th
    push_f(11'h010); push_done();
    start_run(11'h010);
    wait_done("halt");

    // CONST -1 sets n: BRzp falls through, BRnp taken to 0x045
    push_f(11'h040); push_wb(5'd3, '1, 1'b0);
    push_f(11'h041); push_f(11'h042); push_f(11'h045); push_done();
    start_run(11'h040);
    wait_done("const");

    // SUB to zero, BRz taken; i_start during busy ignored
    push_f(11'h020); push_wb(5'd4, '0, 1'b0);
    push_f(11'h021); push_f(11'h026); push_done();
    start_run(11'h020);
    @(posedge clk); #1 i_start = 1'b1; i_start_pc = 11'h3AB;
    @(posedge clk); #1 i_start = 1'b0; i_start_pc = '0;
    wait_done("brz_t");

    set_reg(5'd2, W'(4));
    push_f(11'h020); push_wb(5'd4, W'(1), 1'b0);
    push_f(11'h021); push_f(11'h022); push_done();
    start_run(11'h020);
    wait_done("brz_nt");

    // CHKL sets carry; TCDH sees it and writes -1
    set_reg(5'd1, W'(1));
    push_f(11'h030); push_f(11'h031); push_wb(5'd5, '1, 1'b1);
    push_f(11'h032); push_done();
    start_run(11'h030);
    wait_done("carry");

    // PC wrap 0x7FF -> 0x000
    push_f(11'h7FF); push_f(11'h000); push_done();
    start_run(11'h7FF);
    wait_done("wrap");

    chk("ill_pre", {255'b0, o_illegal}, '0);
    push_f(11'h050); push_wb(5'd6, W'(5), 1'b1);
    push_f(11'h051); push_f(11'h052); push_done();
    start_run(11'h050);
    wait_done("illegal");
    chk("ill_set", {255'b0, o_illegal}, W'(1));

    // Reset during EXEC of ADD: no write, back to reset state
    push_f(11'h060);
    start_run(11'h060);
    chk("ill_clr", {255'b0, o_illegal}, '0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    reset_outputs("abort");
    chk("abort_r7", rf[7], W'(32'h77));
    chk("abort_drain", W'(sb.size()), '0);
    sb.delete();

    // Post-reset flags: nzp=z makes BRz taken; carry=0 seen by TCDH
    push_f(11'h070); push_f(11'h072); push_wb(5'd8, '1, 1'b0);
    push_f(11'h073); push_done();
    start_run(11'h070);
    wait_done("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
